fft8_frame_ctrl: RTL and testbench
==================================

Name: fft8_frame_ctrl

Overview:
Sequencer that wraps the 8-point parallel FFT core. It collects 8 complex samples from a serial valid/ready stream and presents them to the core as one parallel frame. It then waits the core's fixed pipeline latency, captures the 8 results and streams them out serially with a last-flag. It is the only block that drives the core's x inputs and reads its y outputs; it holds one frame in flight at a time.

Parameters:
CORE_LAT, 3, cycles from core_x stable to core_y valid (range 1..15)
DW, 8, width of each real/imag component

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
s_valid  in  1  input sample valid
s_ready  out  1  controller accepts input sample
s_real  in  DW  input sample real part
s_img  in  DW  input sample imaginary part
core_x_real  out  8*DW  packed core inputs; x0 in bits [DW-1:0], x7 in top slice
core_x_img  out  8*DW  packed core inputs, same packing
core_y_real  in  8*DW  packed core outputs, same packing
core_y_img  in  8*DW  packed core outputs, same packing
m_valid  out  1  output sample valid
m_ready  in  1  downstream accepts output sample
m_real  out  DW  output sample real part
m_img  out  DW  output sample imaginary part
m_index  out  3  bin index of current output sample
m_last  out  1  high with the 8th output sample of a frame
busy  out  1  high in any state other than LOAD with 0 samples held

Behaviour:
- Reset is synchronous, active-high, on clk.
- Reset values: state=LOAD, load count=0, s_ready=1, m_valid=0, m_real=0, m_img=0, m_index=0, m_last=0, busy=0, core_x_real=0, core_x_img=0, output buffer cleared.
- LOAD: s_ready=1. Each cycle with s_valid&s_ready, the sample is written to slot[load count] (x0 first) and the count increments. When the 8th sample is accepted (count 7), go to WAIT with the wait counter set to 0. s_ready is registered low from the next cycle.
- WAIT: s_ready=0. core_x_* is driven from the slot registers and stays stable for the whole state. The counter increments each cycle. When the counter equals CORE_LAT-1, latch all 8 core_y_* values into the output buffer, then go to UNLOAD with the output pointer at 0.
- UNLOAD: m_valid=1. m_real/m_img/m_index reflect buffer[ptr]. m_last=1 when ptr=7. On m_valid&m_ready, ptr increments. After the handshake at ptr=7, go to LOAD (count=0, m_valid=0, s_ready=1 the next cycle). The outputs m_* are registered and must not change while m_valid=1 and m_ready=0.
- Latency: the first output is valid CORE_LAT+1 cycles after the cycle in which the 8th input is accepted.
- Full frame throughput with m_ready held high: 8 load + CORE_LAT + 8 unload cycles. There is no overlap between frames.
- Data passes through without modification: no scaling, no saturation, width DW in and out.
- s_valid while s_ready=0 is ignored, with no side effects.
- core_x_* holds the last loaded frame during LOAD of the next frame. Slots update as new samples arrive.
- Reset mid-operation, in any state: the partial or in-flight frame is discarded and all outputs return to their reset values on the next edge.

Optional Feature:
FFT8_BITREV_OUT_EN.
- Defined: in UNLOAD the buffer is read at bitrev3(ptr), i.e. order 0,4,2,6,1,5,3,7. m_index reports the bit-reversed value. m_last still asserts on the 8th transfer.
- Undefined: natural order 0..7 and m_index=ptr.

Test Plan:
- Stub core = identity delayed CORE_LAT. Feed real 1..8, img 0 with m_ready=1 -> m_real 1..8 in order, m_index 0..7, m_last only on value 8, first m_valid exactly 4 cycles after the 8th accept.
- Same frame, m_ready toggling 1,0,0,1... -> no samples lost or duplicated. m_real holds stable during stalls. s_ready stays 0 until after the 8th output handshake.
- s_valid held high through all states -> exactly 8 accepts per frame. Samples offered during WAIT/UNLOAD are not captured. The second frame is 9..16.
- Assert rst after 5 accepts, then load 8 new samples 20..27 -> output 20..27. No remnant of the first 5 samples appears.
- Assert rst during UNLOAD at ptr=3 -> next cycle m_valid=0, s_ready=1, m_index=0, busy=0.
- With FFT8_BITREV_OUT_EN and input 0..7 -> m_real sequence 0,4,2,6,1,5,3,7, with m_index matching.

Source files
------------

// File: rtl/fft8_frame_ctrl_if.sv
// Serial sample streams around the 8-point FFT frame controller: input stream (s_*) and output stream (m_*).
// The slave modport is the controller's view; the master modport is the surrounding environment's view.
interface fft8_frame_ctrl_if #(
    parameter int DW = 8
);
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_real;
    logic [DW-1:0] s_img;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_real;
    logic [DW-1:0] m_img;
    logic [2:0]    m_index;
    logic          m_last;

    modport slave (
        input  s_valid, s_real, s_img, m_ready,
        output s_ready, m_valid, m_real, m_img, m_index, m_last
    );

    modport master (
        output s_valid, s_real, s_img, m_ready,
        input  s_ready, m_valid, m_real, m_img, m_index, m_last
    );
endinterface

// File: rtl/fft8_frame_ctrl.sv
// Frame sequencer for the 8-point parallel FFT core: serial load, fixed-latency wait, serial unload.
// Optional macro FFT8_BITREV_OUT_EN: unload the result buffer in bit-reversed bin order.
module fft8_frame_ctrl #(
    parameter int CORE_LAT = 3,
    parameter int DW       = 8
) (
    input  logic                clk,
    input  logic                rst,
    fft8_frame_ctrl_if.slave    bus,
    output logic [8*DW-1:0]     core_x_real_o,
    output logic [8*DW-1:0]     core_x_img_o,
    input  logic [8*DW-1:0]     core_y_real_i,
    input  logic [8*DW-1:0]     core_y_img_i,
    output logic                busy_o
);
    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_UNLOAD = 2'd2
    } state_t;

    state_t          state_q;
    logic [2:0]      load_cnt_q;
    logic [3:0]      wait_cnt_q;
    logic [2:0]      ptr_q;
    logic [8*DW-1:0] slot_real_q;
    logic [8*DW-1:0] slot_img_q;
    logic [8*DW-1:0] obuf_real_q;
    logic [8*DW-1:0] obuf_img_q;
    logic            s_ready_q;
    logic            m_valid_q;
    logic [DW-1:0]   m_real_q;
    logic [DW-1:0]   m_img_q;
    logic [2:0]      m_index_q;
    logic            m_last_q;
    logic            busy_q;
    logic [2:0]      next_ptr_s;

    function automatic logic [2:0] rd_idx(input logic [2:0] p);
`ifdef FFT8_BITREV_OUT_EN
        return {p[0], p[1], p[2]};
`else
        return p;
`endif
    endfunction

    function automatic logic [DW-1:0] lane(input logic [8*DW-1:0] v, input logic [2:0] i);
        return v[int'(i)*DW +: DW];
    endfunction

    assign next_ptr_s = ptr_q + 3'd1;

    // Frame sequencer: load slots, wait out the core latency, then stream the captured results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            load_cnt_q  <= 3'd0;
            wait_cnt_q  <= 4'd0;
            ptr_q       <= 3'd0;
            slot_real_q <= '0;
            slot_img_q  <= '0;
            obuf_real_q <= '0;
            obuf_img_q  <= '0;
            s_ready_q   <= 1'b1;
            m_valid_q   <= 1'b0;
            m_real_q    <= '0;
            m_img_q     <= '0;
            m_index_q   <= 3'd0;
            m_last_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (bus.s_valid && s_ready_q) begin
                        slot_real_q[int'(load_cnt_q)*DW +: DW] <= bus.s_real;
                        slot_img_q[int'(load_cnt_q)*DW +: DW]  <= bus.s_img;
                        busy_q <= 1'b1;
                        if (load_cnt_q == 3'd7) begin
                            state_q    <= ST_WAIT;
                            load_cnt_q <= 3'd0;
                            wait_cnt_q <= 4'd0;
                            s_ready_q  <= 1'b0;
                        end else begin
                            load_cnt_q <= load_cnt_q + 3'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    // The first output word is taken straight from the core since the buffer loads on this same edge.
                    if (wait_cnt_q == 4'(CORE_LAT - 1)) begin
                        obuf_real_q <= core_y_real_i;
                        obuf_img_q  <= core_y_img_i;
                        ptr_q       <= 3'd0;
                        m_valid_q   <= 1'b1;
                        m_real_q    <= lane(core_y_real_i, rd_idx(3'd0));
                        m_img_q     <= lane(core_y_img_i, rd_idx(3'd0));
                        m_index_q   <= rd_idx(3'd0);
                        m_last_q    <= 1'b0;
                        state_q     <= ST_UNLOAD;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 4'd1;
                    end
                end
                ST_UNLOAD: begin
                    if (bus.m_ready) begin
                        if (ptr_q == 3'd7) begin
                            state_q   <= ST_LOAD;
                            ptr_q     <= 3'd0;
                            m_valid_q <= 1'b0;
                            m_real_q  <= '0;
                            m_img_q   <= '0;
                            m_index_q <= 3'd0;
                            m_last_q  <= 1'b0;
                            s_ready_q <= 1'b1;
                            busy_q    <= 1'b0;
                        end else begin
                            ptr_q     <= next_ptr_s;
                            m_real_q  <= lane(obuf_real_q, rd_idx(next_ptr_s));
                            m_img_q   <= lane(obuf_img_q, rd_idx(next_ptr_s));
                            m_index_q <= rd_idx(next_ptr_s);
                            m_last_q  <= (next_ptr_s == 3'd7);
                        end
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    assign core_x_real_o = slot_real_q;
    assign core_x_img_o  = slot_img_q;
    assign bus.s_ready   = s_ready_q;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_real    = m_real_q;
    assign bus.m_img     = m_img_q;
    assign bus.m_index   = m_index_q;
    assign bus.m_last    = m_last_q;
    assign busy_o        = busy_q;
endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// Bench for fft8_frame_ctrl: identity core stub plus a frame-level reference model compared every cycle.
module tb_fft8_frame_ctrl;
    localparam int CORE_LAT = 3;
    localparam int DW       = 8;

    logic            clk;
    logic            rst;
    logic [8*DW-1:0] cxr, cxi, cyr, cyi;
    logic            busy;
    logic [8*DW-1:0] d1_r, d1_i, d2_r, d2_i;

    int vectors;
    int miscompares;

    fft8_frame_ctrl_if #(.DW(DW)) bus ();

    fft8_frame_ctrl #(.CORE_LAT(CORE_LAT), .DW(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .core_x_real_o (cxr),
        .core_x_img_o  (cxi),
        .core_y_real_i (cyr),
        .core_y_img_i  (cyi),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Identity core: y shows x CORE_LAT cycles after x settles (cycle x settles counts as the first).
    always @(posedge clk) begin
        d1_r <= cxr;
        d1_i <= cxi;
        d2_r <= d1_r;
        d2_i <= d1_i;
    end
    assign cyr = d2_r;
    assign cyi = d2_i;

    // Reference model: frame-level view of what the controller holds.
    logic [7:0] sl_r[8], sl_i[8], fr_r[8], fr_i[8];
    int ld_n, out_k, wait_m, frames_done;
    bit pending;

    function automatic int ord(input int k);
`ifdef FFT8_BITREV_OUT_EN
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
`else
        return k;
`endif
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 8; j++) begin
            sl_r[j] = 8'd0;
            sl_i[j] = 8'd0;
        end
        ld_n = 0;
        out_k = 0;
        wait_m = 0;
        pending = 1'b0;
    endtask

    function automatic logic [150:0] model_vec();
        logic [63:0] xr, xi;
        logic        mv;
        logic [19:0] mf;
        for (int j = 0; j < 8; j++) begin
            xr[j*8 +: 8] = sl_r[j];
            xi[j*8 +: 8] = sl_i[j];
        end
        mv = pending && (wait_m == 0);
        mf = 20'd0;
        if (mv) mf = {fr_r[ord(out_k)], fr_i[ord(out_k)], 3'(ord(out_k)), 1'(out_k == 7)};
        return {!pending, mv, 1'((ld_n != 0) || pending), mf, xr, xi};
    endfunction

    function automatic logic [150:0] dut_vec();
        logic [19:0] mf;
        mf = bus.m_valid ? {bus.m_real, bus.m_img, bus.m_index, bus.m_last} : 20'd0;
        return {bus.s_ready, bus.m_valid, busy, mf, cxr, cxi};
    endfunction

    // Drive one cycle of inputs and advance the model across the following rising edge.
    task automatic apply(input bit r, input bit sv, input logic [7:0] sr, input logic [7:0] si,
                         input bit mr, output bit acc);
        bit fire;
        rst = r;
        bus.s_valid = sv;
        bus.s_real = sr;
        bus.s_img = si;
        bus.m_ready = mr;
        acc = !r && sv && !pending;
        fire = !r && pending && (wait_m == 0) && mr;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (wait_m > 0) wait_m--;
            if (fire) begin
                out_k++;
                if (out_k == 8) begin
                    out_k = 0;
                    pending = 1'b0;
                    frames_done++;
                end
            end
            if (acc) begin
                sl_r[ld_n] = sr;
                sl_i[ld_n] = si;
                ld_n++;
                if (ld_n == 8) begin
                    fr_r = sl_r;
                    fr_i = sl_i;
                    ld_n = 0;
                    out_k = 0;
                    pending = 1'b1;
                    wait_m = CORE_LAT;
                end
            end
        end
    endtask

    task automatic test_reset();
        bit acc;
        apply(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, acc);
        apply(1'b1, 1'b1, 8'h5a, 8'ha5, 1'b1, acc);
        @(negedge clk);
        vectors++;
        if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL reset_state got=%h exp=%h", dut_vec(), model_vec());
        end
        vectors++;
        if ({bus.m_real, bus.m_img, bus.m_index, bus.m_last, cxr, cxi} !== 148'd0) begin
            miscompares++;
            $display("FAIL reset_zero got=%h exp=0", {bus.m_real, bus.m_img, bus.m_index, bus.m_last, cxr, cxi});
        end
    endtask

    task automatic test_basic();
        int v = 1, cyc = 0, goal = frames_done + 1;
        bit acc;
        while (frames_done < goal && cyc < 200) begin
            @(negedge clk);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL basic cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
            end
            apply(1'b0, (v <= 8), 8'(v), 8'd0, 1'b1, acc);
            if (acc) v++;
            cyc++;
        end
        vectors++;
        if (frames_done < goal) begin
            miscompares++;
            $display("FAIL basic_timeout frames=%0d required=%0d", frames_done, goal);
        end
    endtask

    task automatic test_stall();
        int v = 1, cyc = 0, goal = frames_done + 1;
        bit acc;
        while (frames_done < goal && cyc < 300) begin
            @(negedge clk);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL stall cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
            end
            apply(1'b0, (v <= 8), 8'(v), 8'(v * 3), (cyc % 3 == 0), acc);
            if (acc) v++;
            cyc++;
        end
        vectors++;
        if (frames_done < goal) begin
            miscompares++;
            $display("FAIL stall_timeout frames=%0d required=%0d", frames_done, goal);
        end
    endtask

    task automatic test_svalid_hold();
        int v = 1, cyc = 0, goal = frames_done + 2;
        bit acc;
        while (frames_done < goal && cyc < 300) begin
            @(negedge clk);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL svalid_hold cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
            end
            apply(1'b0, 1'b1, pending ? 8'($urandom_range(100, 255)) : 8'(v), 8'($urandom), 1'b1, acc);
            if (acc) v++;
            cyc++;
        end
        vectors++;
        if (frames_done < goal || v != 17) begin
            miscompares++;
            $display("FAIL svalid_hold_count frames=%0d next_value=%0d required=%0d/17", frames_done, v, goal);
        end
    endtask

    task automatic test_reset_mid_load();
        int v = 0, cyc = 0, goal;
        bit acc;
        while (v < 5 && cyc < 50) begin
            @(negedge clk);
            apply(1'b0, 1'b1, 8'(200 + v), 8'(v), 1'b1, acc);
            if (acc) v++;
            cyc++;
        end
        apply(1'b1, 1'b1, 8'd0, 8'd0, 1'b1, acc);
        @(negedge clk);
        vectors++;
        if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL mid_load_reset got=%h exp=%h", dut_vec(), model_vec());
        end
        v = 20;
        cyc = 0;
        goal = frames_done + 1;
        while (frames_done < goal && cyc < 200) begin
            if (cyc > 0) @(negedge clk);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL mid_load_frame cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
            end
            apply(1'b0, (v <= 27), 8'(v), 8'd7, 1'b1, acc);
            if (acc) v++;
            cyc++;
        end
        vectors++;
        if (frames_done < goal) begin
            miscompares++;
            $display("FAIL mid_load_timeout frames=%0d required=%0d", frames_done, goal);
        end
    endtask

    task automatic test_reset_unload();
        int v = 1, cyc = 0;
        bit acc;
        while (!(pending && wait_m == 0 && out_k == 3) && cyc < 100) begin
            @(negedge clk);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL unload_run cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
            end
            apply(1'b0, (v <= 8), 8'(v + 40), 8'(v), 1'b1, acc);
            if (acc) v++;
            cyc++;
        end
        vectors++;
        if (!(pending && out_k == 3)) begin
            miscompares++;
            $display("FAIL unload_reach out_k=%0d required=3", out_k);
        end
        @(negedge clk);
        apply(1'b1, 1'b0, 8'd0, 8'd0, 1'b1, acc);
        @(negedge clk);
        vectors++;
        if ({bus.m_valid, bus.s_ready, bus.m_index, busy} !== 6'b0_1_000_0) begin
            miscompares++;
            $display("FAIL unload_reset got=%b required=010000", {bus.m_valid, bus.s_ready, bus.m_index, busy});
        end
        vectors++;
        if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL unload_reset_vec got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_random();
        int cyc = 0, goal = frames_done + 4;
        bit acc;
        while (frames_done < goal && cyc < 1000) begin
            @(negedge clk);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
            end
            apply(1'b0, ($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 9) < 6), acc);
            cyc++;
        end
        vectors++;
        if (frames_done < goal) begin
            miscompares++;
            $display("FAIL random_timeout frames=%0d required=%0d", frames_done, goal);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        frames_done = 0;
        model_reset();
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_real = 8'd0;
        bus.s_img = 8'd0;
        bus.m_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_svalid_hold();
        test_reset_mid_load();
        test_reset_unload();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
